// File: rtl/f_eval_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : f_eval_ctrl_pkg
// Description : Shared types and constants for the f evaluation controller:
//               FSM state encoding, operand code width and the reference
//               truth table of f.
// Revision    : 1.0 - initial release
// ============================================================================
package f_eval_ctrl_pkg;

   // Operand code width: {in1,in2,in3,in4}
   localparam int CODE_W = 4;

   // Truth table of f, bit i = f(code i); ones at codes 1, 2, 3, 7, 13
   localparam logic [15:0] F_TT = 16'h208E;

   typedef logic [CODE_W-1:0] code_t;

   // Controller states, explicit 3-bit encoding
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SERVE = 3'd1,
      ST_SWEEP = 3'd2,
      ST_WAIT  = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

endpackage : f_eval_ctrl_pkg
`default_nettype wire

// File: rtl/f_eval_ctrl_f.sv
`default_nettype none
// ============================================================================
// Module      : f_eval_ctrl_f
// Description : The existing 4-input combinational function f.
//               out = 1 exactly for {in1,in2,in3,in4} = 1, 2, 3, 7, 13.
// Revision    : 1.0 - initial release
// ============================================================================
module f_eval_ctrl_f (
   input  logic i_in1,
   input  logic i_in2,
   input  logic i_in3,
   input  logic i_in4,
   output logic o_out
);

   // Sum of products: codes 1..3, code 7, code 13
   assign o_out = (~i_in1 & ~i_in2 & (i_in3 | i_in4))
                | (~i_in1 &  i_in2 &  i_in3 &  i_in4)
                | ( i_in1 &  i_in2 & ~i_in3 &  i_in4);

endmodule : f_eval_ctrl_f
`default_nettype wire

// File: rtl/f_eval_ctrl_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : f_eval_ctrl_rr_arb2
// Description : Two-requester round-robin arbiter. A lone request wins; on a
//               tie the requester not granted last wins. The pointer only
//               moves when the caller commits the grant via i_take.
// Revision    : 1.0 - initial release
// ============================================================================
module f_eval_ctrl_rr_arb2 (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic [1:0] i_req,
   input  logic       i_take,
   output logic [1:0] o_win
);

   // Index of the requester granted last; reset value 1 favours requester 0
   logic r_last;

   // Winner selection from current requests and the last-granted pointer
   always_comb begin
      o_win = 2'b00;
      case (i_req)
         2'b01:   o_win = 2'b01;
         2'b10:   o_win = 2'b10;
         2'b11:   o_win = r_last ? 2'b01 : 2'b10;
         default: o_win = 2'b00;
      endcase
   end

   // Pointer update on a committed grant
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_last <= 1'b1;
      end else if (i_take && (|i_req)) begin
         r_last <= o_win[1];
      end
   end

endmodule : f_eval_ctrl_rr_arb2
`default_nettype wire

// File: rtl/f_eval_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : f_eval_ctrl
// Description : Controller around a single shared instance of f. Serves
//               round-robin arbitrated point queries from two requesters and
//               runs full 16-entry truth-table sweeps with optional idle
//               cycles between steps. All outputs are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module f_eval_ctrl #(
   parameter int PAUSE = 0
) (
   input  logic        JM1222HM_clk,
   input  logic        JM1222HM_rst_n,
   input  logic        JM1222HM_start,
   input  logic [1:0]  JM1222HM_req,
   input  logic [3:0]  JM1222HM_code0,
   input  logic [3:0]  JM1222HM_code1,
   output logic [1:0]  JM1222HM_gnt,
   output logic [1:0]  JM1222HM_rsp_valid,
   output logic        JM1222HM_rsp_data,
   output logic        JM1222HM_busy,
   output logic        JM1222HM_done,
   output logic [15:0] JM1222HM_table
);

   import f_eval_ctrl_pkg::*;

   localparam code_t      c_LAST_INDEX = code_t'(15);
   // Final WAIT count before leaving WAIT; unused when PAUSE is 0
   localparam logic [3:0] c_PAUSE_LAST = (PAUSE > 0) ? 4'(PAUSE - 1) : 4'd0;

   state_t      r_state;
   state_t      w_next_state;
   code_t       r_index;
   logic [3:0]  r_wait;
   code_t       r_code;
   logic [1:0]  r_winner;
   logic [15:0] r_table;
   logic [1:0]  r_gnt;
   logic [1:0]  r_rsp_valid;
   logic        r_rsp_data;
   logic        r_busy;
   logic        r_done;

   code_t       w_index_nxt;
   logic [3:0]  w_wait_nxt;
   code_t       w_code_nxt;
   logic [1:0]  w_winner_nxt;
   logic [15:0] w_table_nxt;
   logic [1:0]  w_gnt_nxt;
   logic [1:0]  w_rsp_valid_nxt;
   logic        w_rsp_data_nxt;

   logic [1:0]  w_win;
   logic        w_take;
   code_t       w_f_code;
   logic        w_f;

   // A grant is committed on every transition into SERVE
   assign w_take = (w_next_state == ST_SERVE);

   f_eval_ctrl_rr_arb2 u_arb (
      .i_clk   (JM1222HM_clk),
      .i_rst_n (JM1222HM_rst_n),
      .i_req   (JM1222HM_req),
      .i_take  (w_take),
      .o_win   (w_win)
   );

   // The shared f evaluates the latched query code in SERVE, the sweep index otherwise
   assign w_f_code = (r_state == ST_SERVE) ? r_code : r_index;

   f_eval_ctrl_f u_f (
      .i_in1 (w_f_code[3]),
      .i_in2 (w_f_code[2]),
      .i_in3 (w_f_code[1]),
      .i_in4 (w_f_code[0]),
      .o_out (w_f)
   );

   // State register
   always_ff @(posedge JM1222HM_clk or negedge JM1222HM_rst_n) begin
      if (!JM1222HM_rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic; the edge leaving DONE counts as the return to IDLE,
   // so a request pending during a sweep is granted right after done
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: begin
            if (JM1222HM_start) begin
               w_next_state = ST_SWEEP;
            end else if (|JM1222HM_req) begin
               w_next_state = ST_SERVE;
            end
         end
         ST_SERVE: w_next_state = ST_IDLE;
         ST_SWEEP: begin
            if (PAUSE > 0) begin
               w_next_state = ST_WAIT;
            end else if (r_index == c_LAST_INDEX) begin
               w_next_state = ST_DONE;
            end else begin
               w_next_state = ST_SWEEP;
            end
         end
         ST_WAIT: begin
            if (r_wait == c_PAUSE_LAST) begin
               w_next_state = (r_index == c_LAST_INDEX) ? ST_DONE : ST_SWEEP;
            end
         end
         ST_DONE: w_next_state = (|JM1222HM_req) ? ST_SERVE : ST_IDLE;
         default: w_next_state = ST_IDLE;
      endcase
   end

   // Output and datapath next values, registered below
   always_comb begin
      w_index_nxt     = r_index;
      w_wait_nxt      = r_wait;
      w_code_nxt      = r_code;
      w_winner_nxt    = r_winner;
      w_table_nxt     = r_table;
      w_gnt_nxt       = 2'b00;
      w_rsp_valid_nxt = 2'b00;
      w_rsp_data_nxt  = 1'b0;

      if (w_take) begin
         w_gnt_nxt    = w_win;
         w_winner_nxt = w_win;
         w_code_nxt   = w_win[1] ? JM1222HM_code1 : JM1222HM_code0;
      end

      case (r_state)
         ST_IDLE: begin
            if (JM1222HM_start) begin
               w_table_nxt = 16'h0000;
               w_index_nxt = '0;
            end
         end
         ST_SERVE: begin
            w_rsp_valid_nxt = r_winner;
            w_rsp_data_nxt  = w_f;
         end
         ST_SWEEP: begin
            w_table_nxt[r_index] = w_f;
            w_wait_nxt           = 4'd0;
            if (w_next_state == ST_SWEEP) begin
               w_index_nxt = r_index + code_t'(1);
            end
         end
         ST_WAIT: begin
            w_wait_nxt = r_wait + 4'd1;
            if (w_next_state == ST_SWEEP) begin
               w_index_nxt = r_index + code_t'(1);
            end
         end
         default: ;
      endcase
   end

   // Output and datapath registers; reset aborts any sweep or query at once
   always_ff @(posedge JM1222HM_clk or negedge JM1222HM_rst_n) begin
      if (!JM1222HM_rst_n) begin
         r_index     <= '0;
         r_wait      <= 4'd0;
         r_code      <= '0;
         r_winner    <= 2'b00;
         r_table     <= 16'h0000;
         r_gnt       <= 2'b00;
         r_rsp_valid <= 2'b00;
         r_rsp_data  <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_index     <= w_index_nxt;
         r_wait      <= w_wait_nxt;
         r_code      <= w_code_nxt;
         r_winner    <= w_winner_nxt;
         r_table     <= w_table_nxt;
         r_gnt       <= w_gnt_nxt;
         r_rsp_valid <= w_rsp_valid_nxt;
         r_rsp_data  <= w_rsp_data_nxt;
         r_busy      <= (w_next_state != ST_IDLE);
         r_done      <= (w_next_state == ST_DONE);
      end
   end

   assign JM1222HM_gnt       = r_gnt;
   assign JM1222HM_rsp_valid = r_rsp_valid;
   assign JM1222HM_rsp_data  = r_rsp_data;
   assign JM1222HM_busy      = r_busy;
   assign JM1222HM_done      = r_done;
   assign JM1222HM_table     = r_table;

endmodule : f_eval_ctrl
`default_nettype wire

// File: tb/tb_f_eval_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_f_eval_ctrl
// Description : Scoreboard bench for f_eval_ctrl. Stimulus tasks push the
//               expected grant/response/done events with their cycle stamps;
//               a negedge monitor pops and compares them as the DUT emits.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_f_eval_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [1:0]  req = 2'b00;
   logic [3:0]  code0 = 4'd0;
   logic [3:0]  code1 = 4'd0;
   logic [1:0]  gnt, rsp_valid;
   logic        rsp_data, busy, done;
   logic [15:0] tbl;

   logic        start2 = 1'b0;
   logic [1:0]  req2 = 2'b00;
   logic [3:0]  zc = 4'd0;
   logic [1:0]  gnt2, rv2;
   logic        rd2, busy2, done2;
   logic [15:0] tbl2;

   f_eval_ctrl #(.PAUSE(0)) u_dut (
      .JM1222HM_clk(clk), .JM1222HM_rst_n(rst_n), .JM1222HM_start(start),
      .JM1222HM_req(req), .JM1222HM_code0(code0), .JM1222HM_code1(code1),
      .JM1222HM_gnt(gnt), .JM1222HM_rsp_valid(rsp_valid), .JM1222HM_rsp_data(rsp_data),
      .JM1222HM_busy(busy), .JM1222HM_done(done), .JM1222HM_table(tbl)
   );

   f_eval_ctrl #(.PAUSE(2)) u_dut_p2 (
      .JM1222HM_clk(clk), .JM1222HM_rst_n(rst_n), .JM1222HM_start(start2),
      .JM1222HM_req(req2), .JM1222HM_code0(zc), .JM1222HM_code1(zc),
      .JM1222HM_gnt(gnt2), .JM1222HM_rsp_valid(rv2), .JM1222HM_rsp_data(rd2),
      .JM1222HM_busy(busy2), .JM1222HM_done(done2), .JM1222HM_table(tbl2)
   );

   always #5 clk = ~clk;

   // Edge counter: at a negedge, cyc equals the number of rising edges so far
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int         c;
      logic [1:0] v;
      logic       d;
   } exp_t;

   exp_t        q_gnt[$];
   exp_t        q_rsp[$];
   int          q_done[$];
   logic [15:0] q_tbl[$];
   int          tests = 0;
   int          fails = 0;
   int          m_last = 1;   // requester granted last; 1 after reset

   function automatic logic f_ref(input logic [3:0] c);
      return (c == 4'd1) || (c == 4'd2) || (c == 4'd3) || (c == 4'd7) || (c == 4'd13);
   endfunction

   function automatic logic [15:0] tbl_ref();
      logic [15:0] t;
      for (int i = 0; i < 16; i++) t[i] = f_ref(4'(i));
      return t;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: compare every DUT event against the head of its queue
   always @(negedge clk) begin
      exp_t e;
      if ((|gnt) || (|rsp_valid)) begin
         chk("onehot_excl", {31'd0, ($countones(gnt) <= 1) && ($countones(rsp_valid) <= 1)
                                    && !((|gnt) && (|rsp_valid))}, 32'd1);
      end
      if (|gnt) begin
         if (q_gnt.size() == 0) begin
            chk("gnt_unexpected", {30'd0, gnt}, 32'd0);
         end else begin
            e = q_gnt.pop_front();
            chk("gnt_value", {30'd0, gnt}, {30'd0, e.v});
            chk("gnt_cycle", cyc, e.c);
         end
      end
      if (|rsp_valid) begin
         if (q_rsp.size() == 0) begin
            chk("rsp_unexpected", {30'd0, rsp_valid}, 32'd0);
         end else begin
            e = q_rsp.pop_front();
            chk("rsp_valid", {30'd0, rsp_valid}, {30'd0, e.v});
            chk("rsp_data", {31'd0, rsp_data}, {31'd0, e.d});
            chk("rsp_cycle", cyc, e.c);
         end
      end
      if (done) begin
         if (q_done.size() == 0) begin
            chk("done_unexpected", {31'd0, done}, 32'd0);
         end else begin
            chk("done_cycle", cyc, q_done.pop_front());
            chk("done_table", {16'd0, tbl}, {16'd0, q_tbl.pop_front()});
         end
      end
   end

   // Query: hold req for k grants (tie bursts alternate), called at a negedge in IDLE
   task automatic do_query(input logic [1:0] r_req, input int k,
                           input logic [3:0] c0, input logic [3:0] c1);
      int base;
      int w;
      base  = cyc;
      req   = r_req;
      code0 = c0;
      code1 = c1;
      for (int j = 0; j < k; j++) begin
         if (r_req == 2'b11) w = (m_last == 1) ? 0 : 1;
         else                w = r_req[1] ? 1 : 0;
         m_last = w;
         q_gnt.push_back('{base + 1 + 2*j, 2'(1 << w), 1'b0});
         q_rsp.push_back('{base + 2 + 2*j, 2'(1 << w), f_ref((w == 1) ? c1 : c0)});
      end
      repeat (2*k - 1) @(posedge clk);
      @(negedge clk);
      req = 2'b00;
      @(posedge clk);
      @(negedge clk);
   endtask

   // Sweep, optionally with a request raised in the same cycle as start
   task automatic do_sweep(input logic with_req, input int r, input logic [3:0] c);
      int base;
      base = cyc;
      start = 1'b1;
      q_done.push_back(base + 17);
      q_tbl.push_back(tbl_ref());
      if (with_req) begin
         req   = 2'(1 << r);
         code0 = c;
         code1 = c;
         m_last = r;
         q_gnt.push_back('{base + 18, 2'(1 << r), 1'b0});
         q_rsp.push_back('{base + 19, 2'(1 << r), f_ref(c)});
      end
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      chk("busy_sweep", {31'd0, busy}, 32'd1);
      for (int i = 0; i < 15; i++) begin
         @(posedge clk);
         @(negedge clk);
         chk("busy_sweep", {31'd0, busy}, 32'd1);
      end
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      req = 2'b00;
      if (with_req) begin
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   // Reset asserted while the sweep index is 5
   task automatic do_reset_mid_sweep();
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      chk("pre_reset_table_nonzero", {31'd0, (tbl != 16'h0000)}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("abort_table", {16'd0, tbl}, 32'd0);
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_done", {31'd0, done}, 32'd0);
      m_last = 1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (30) @(negedge clk);
      chk("post_abort_table", {16'd0, tbl}, 32'd0);
      chk("post_abort_busy", {31'd0, busy}, 32'd0);
   endtask

   // PAUSE=2 instance: done 49 cycles after start, full table
   task automatic do_pause_sweep();
      int base;
      int n;
      base = cyc;
      n = 0;
      start2 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start2 = 1'b0;
      while (!done2 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("pause_done_seen", {31'd0, done2}, 32'd1);
      chk("pause_done_cycle", cyc - base, 49);
      chk("pause_table", {16'd0, tbl2}, {16'd0, tbl_ref()});
      @(negedge clk);
      chk("pause_done_pulse", {31'd0, done2}, 32'd0);
      chk("pause_idle", {31'd0, busy2}, 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int kind;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_gnt", {30'd0, gnt}, 32'd0);
      chk("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
      chk("rst_rsp_data", {31'd0, rsp_data}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_table", {16'd0, tbl}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      do_query(2'b11, 3, 4'd7, 4'd8);
      do_sweep(1'b0, 0, 4'd0);
      do_query(2'b01, 1, 4'd7, 4'd0);
      do_query(2'b01, 1, 4'd8, 4'd0);
      do_query(2'b10, 1, 4'd0, 4'd13);
      do_sweep(1'b1, 0, 4'd3);
      do_pause_sweep();

      for (int t = 0; t < 30; t++) begin
         kind = $urandom_range(0, 3);
         case (kind)
            0: do_query(2'($urandom_range(1, 2)), $urandom_range(1, 2),
                        4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            1: do_query(2'b11, $urandom_range(2, 4),
                        4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            2: do_sweep(1'($urandom_range(0, 1)), $urandom_range(0, 1),
                        4'($urandom_range(0, 15)));
            default: repeat ($urandom_range(1, 3)) @(negedge clk);
         endcase
      end

      do_reset_mid_sweep();
      do_query(2'b11, 2, 4'd1, 4'd2);
      repeat (5) @(negedge clk);

      chk("pending_expectations", q_gnt.size() + q_rsp.size() + q_done.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule : tb_f_eval_ctrl
`default_nettype wire

// File: doc/f_eval_ctrl.md
F_EVAL_CTRL -- requirements
Module: f_eval_ctrl

Interface
REQ-001 SHALL have parameter PAUSE, default 0: idle cycles inserted after each sweep step (0..15).
REQ-002 SHALL have port JM1222HM_clk, input, 1: single clock; all state changes on its rising edge.
REQ-003 SHALL have port JM1222HM_rst_n, input, 1: asynchronous active-low reset.
REQ-004 SHALL have port JM1222HM_start, input, 1: sweep request, sampled per cycle.
REQ-005 SHALL have port JM1222HM_req, input, 2: per-requester query request, held until granted.
REQ-006 SHALL have port JM1222HM_code0, input, 4: requester 0 operand {in1,in2,in3,in4} = bits [3:0].
REQ-007 SHALL have port JM1222HM_code1, input, 4: requester 1 operand, same mapping.
REQ-008 SHALL have port JM1222HM_gnt, output, 2: one-hot grant pulse, 1 cycle.
REQ-009 SHALL have port JM1222HM_rsp_valid, output, 2: one-hot response pulse, 1 cycle.
REQ-010 SHALL have port JM1222HM_rsp_data, output, 1: function result, valid with rsp_valid.
REQ-011 SHALL have port JM1222HM_busy, output, 1: high in every non-IDLE state.
REQ-012 SHALL have port JM1222HM_done, output, 1: 1-cycle pulse at sweep completion.
REQ-013 SHALL have port JM1222HM_table, output, 16: truth table, bit i = f(code i).

Function
REQ-014 SHALL evaluate the existing 4-input function f (single shared instance), where f(code) = 1 exactly for codes 1, 2, 3, 7 and 13.
REQ-015 SHALL implement the FSM states IDLE, SERVE, SWEEP, WAIT and DONE, all outputs registered.
REQ-016 IDLE: start=1 SHALL go to SWEEP, clear table to 0 and set index to 0; start has priority over req.
REQ-017 IDLE, start=0, req!=0: SHALL pick a winner, latch its code, pulse gnt[winner] next cycle, and enter SERVE.
REQ-018 Arbitration SHALL be round-robin: a single request wins; on a tie the requester not granted last wins; the pointer after reset favours requester 0.
REQ-019 SERVE SHALL last 1 cycle, driving rsp_valid[winner]=1 and rsp_data=f(latched code), then return to IDLE.
REQ-020 Query latency SHALL be fixed: req sampled at edge N -> gnt high in cycle N+1 -> rsp_valid high in cycle N+2; the next arbitration is at the edge ending the SERVE cycle.
REQ-021 SWEEP SHALL write table[index]=f(index) each cycle; if PAUSE>0 it SHALL pass through WAIT for PAUSE cycles before the next index.
REQ-022 After index 15 is written, SHALL enter DONE (done=1 for 1 cycle) and then IDLE; index SHALL NOT wrap within a sweep.
REQ-023 With PAUSE=0, start sampled at edge k -> SWEEP cycles k+1..k+16 -> done high in cycle k+17.
REQ-024 start and req SHALL be ignored in SERVE, SWEEP, WAIT and DONE; pending requests are arbitrated on return to IDLE.
REQ-025 table SHALL hold its value between sweeps and is valid while done=1 or in IDLE after a sweep.
REQ-026 gnt and rsp_valid SHALL never have more than one bit set, and gnt and rsp_valid SHALL never both be high in the same cycle.

Reset
REQ-027 While rst_n=0: state=IDLE, index=0, RR pointer favours requester 0, table=16'h0000, and gnt, rsp_valid, rsp_data, busy and done all 0.
REQ-028 Reset asserted mid-sweep or mid-query SHALL abort immediately; no done or rsp_valid pulse SHALL follow deassertion.

Structure
REQ-029 The state enum, the 4-bit code width and the constant F_TT = 16'h208E SHALL live in the shared calculator package.
REQ-030 A round-robin arbiter sub-module rr_arb2 is natural; f SHALL be instantiated unmodified.

Verification
REQ-031 Reset then start pulse, PAUSE=0 -> done in cycle 17, table=16'h208E, busy high in cycles 1-16.
REQ-032 req=2'b01, code0=4'd7 -> gnt=01 at +1, rsp_valid=01 with rsp_data=1 at +2; code0=4'd8 -> rsp_data=0.
REQ-033 req=2'b11 held for 3 queries -> grants go 01, 10, 01.
REQ-034 start and req=01 in the same cycle -> the sweep runs first; the grant follows done by 1 cycle.
REQ-035 rst_n low at sweep index 5 -> table=0 and busy=0 immediately; no done pulse after release.
REQ-036 PAUSE=2, start -> done at cycle 16*3+1=49 after start, table=16'h208E.
